// File: rtl/bg_pair_reader_pkg.sv
// -----------------------------------------------------------------------------
// bg_pair_reader_pkg
// Shared GPU definitions used by the background pair reader. The write-pair
// packer also uses them.
//   - bg_state_e      : reader FSM states
//   - VRAM_AW         : VRAM 32-bit word address width
//   - pixel field bit positions inside one 16-bit pixel
//   - vram_word_addr(): maps pair coordinates to a VRAM word address
// -----------------------------------------------------------------------------
package bg_pair_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } bg_state_e;

    localparam int VRAM_AW = 18;
    localparam int PIX_W   = 16;
    localparam int CH_W    = 5;
    localparam int R_LSB   = 0;
    localparam int G_LSB   = 5;
    localparam int B_LSB   = 10;
    localparam int MSK_BIT = 15;

    // One word holds a pixel pair, so the X LSB is dropped.
    function automatic logic [VRAM_AW-1:0] vram_word_addr(input logic [9:0] scr_x_mul2,
                                                          input logic [8:0] scr_y);
        return {scr_y, scr_x_mul2[9:1]};
    endfunction

endpackage

// File: rtl/bg_pair_reader_unpack.sv
// -----------------------------------------------------------------------------
// bg_pixel_unpack
// Purely combinational. It splits one 32-bit VRAM word into two pixels.
// The left pixel is in the low half and the right pixel is in the high half.
// Ports:
//   i_word                     32-bit packed pixel pair
//   o_r_l/o_g_l/o_b_l/o_msk_l  left pixel channels and mask
//   o_r_r/o_g_r/o_b_r/o_msk_r  right pixel channels and mask
// -----------------------------------------------------------------------------
module bg_pixel_unpack
    import bg_pair_reader_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [4:0]  o_r_l,
    output logic [4:0]  o_g_l,
    output logic [4:0]  o_b_l,
    output logic        o_msk_l,
    output logic [4:0]  o_r_r,
    output logic [4:0]  o_g_r,
    output logic [4:0]  o_b_r,
    output logic        o_msk_r
);

    assign o_r_l   = i_word[R_LSB +: CH_W];
    assign o_g_l   = i_word[G_LSB +: CH_W];
    assign o_b_l   = i_word[B_LSB +: CH_W];
    assign o_msk_l = i_word[MSK_BIT];
    assign o_r_r   = i_word[PIX_W + R_LSB +: CH_W];
    assign o_g_r   = i_word[PIX_W + G_LSB +: CH_W];
    assign o_b_r   = i_word[PIX_W + B_LSB +: CH_W];
    assign o_msk_r = i_word[PIX_W + MSK_BIT];

endmodule

// File: rtl/bg_pair_reader.sv
// -----------------------------------------------------------------------------
// bg_pair_reader
// Fetches one 32-bit VRAM word that holds a background pixel pair. It unpacks
// the word and hands the pair to a consumer with a valid/ready handshake.
// If the request does not need a background, the block skips VRAM and
// returns zeros.
// Optional feature: define BG_PAIR_CACHE_EN to keep a one-entry word cache.
// i_invalidate clears that cache.
// Ports:
//   clk, i_nrst (synchronous, active-low)
//   request : i_reqValid/o_reqReady, i_scrX_Mul2, i_scrY, i_needBG
//   memory  : o_memReq, o_memAddr, i_memAck, i_memDataValid, i_memData
//   output  : o_bgValid/i_bgReady, unpacked channels, masks, echoed coords
//   i_invalidate : VRAM changed, so the cached word is dropped
// -----------------------------------------------------------------------------
module bg_pair_reader
    import bg_pair_reader_pkg::*;
(
    input  logic                clk,
    input  logic                i_nrst,
    input  logic                i_reqValid,
    output logic                o_reqReady,
    input  logic [9:0]          i_scrX_Mul2,
    input  logic [8:0]          i_scrY,
    input  logic                i_needBG,
    output logic                o_memReq,
    output logic [VRAM_AW-1:0]  o_memAddr,
    input  logic                i_memAck,
    input  logic                i_memDataValid,
    input  logic [31:0]         i_memData,
    output logic                o_bgValid,
    input  logic                i_bgReady,
    output logic [4:0]          o_rBG_L,
    output logic [4:0]          o_gBG_L,
    output logic [4:0]          o_bgBG_L,
    output logic [4:0]          o_rBG_R,
    output logic [4:0]          o_gBG_R,
    output logic [4:0]          o_bBG_R,
    output logic                o_bgMskL,
    output logic                o_bgMskR,
    output logic [9:0]          o_scrX_Mul2,
    output logic [8:0]          o_scrY,
    input  logic                i_invalidate
);

    bg_state_e          state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [8:0]         y_q, y_d;
    logic [31:0]        word_q, word_d;
    logic               mem_req_q, mem_req_d;
    logic               bg_valid_q, bg_valid_d;

    logic               req_ready_s;
    logic               accept_s;
    logic               launch_s;
    logic               capture_s;
    logic               hit_s;
    logic [31:0]        hit_word_s;

    assign req_ready_s = (state_q == ST_IDLE) | ((state_q == ST_OUT) & i_bgReady);
    assign accept_s    = i_reqValid & req_ready_s;

`ifdef BG_PAIR_CACHE_EN
    logic [VRAM_AW-1:0] cache_addr_q, cache_addr_d;
    logic [31:0]        cache_word_q, cache_word_d;
    logic               cache_vld_q, cache_vld_d;

    assign hit_s      = cache_vld_q & (cache_addr_q == vram_word_addr(i_scrX_Mul2, i_scrY));
    assign hit_word_s = cache_word_q;

    // Cache update: a capture loads the cache, and an invalidate in the same cycle wins.
    always_comb begin
        cache_addr_d = cache_addr_q;
        cache_word_d = cache_word_q;
        cache_vld_d  = cache_vld_q;
        if (capture_s) begin
            cache_addr_d = vram_word_addr(x_q, y_q);
            cache_word_d = i_memData;
            cache_vld_d  = 1'b1;
        end else begin
            cache_vld_d  = cache_vld_q;
        end
        if (i_invalidate) begin
            cache_vld_d = 1'b0;
        end else begin
            cache_vld_d = cache_vld_d;
        end
    end

    // Cache registers.
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            cache_addr_q <= {VRAM_AW{1'b0}};
            cache_word_q <= 32'h0000_0000;
            cache_vld_q  <= 1'b0;
        end else begin
            cache_addr_q <= cache_addr_d;
            cache_word_q <= cache_word_d;
            cache_vld_q  <= cache_vld_d;
        end
    end
`else
    logic unused_invalidate_s;
    assign unused_invalidate_s = i_invalidate;
    assign hit_s               = 1'b0;
    assign hit_word_s          = 32'h0000_0000;
`endif

    // FSM next-state logic, request latching and data capture.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        word_d     = word_q;
        launch_s   = 1'b0;
        capture_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    launch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_memAck) begin
                    // Ack and data can arrive in the same cycle, so WAIT is skipped.
                    if (i_memDataValid) begin
                        capture_s = 1'b1;
                        state_d   = ST_OUT;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_memDataValid) begin
                    capture_s = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    state_d   = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (i_bgReady) begin
                    if (accept_s) begin
                        launch_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An accepted request picks its first state: no fetch, cache hit, or VRAM read.
        if (launch_s) begin
            x_d = i_scrX_Mul2;
            y_d = i_scrY;
            if (!i_needBG) begin
                word_d  = 32'h0000_0000;
                state_d = ST_OUT;
            end else if (hit_s) begin
                word_d  = hit_word_s;
                state_d = ST_OUT;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            x_d = x_q;
        end

        if (capture_s) begin
            word_d = i_memData;
        end else begin
            word_d = word_d;
        end

        mem_req_d  = (state_d == ST_REQ);
        bg_valid_d = (state_d == ST_OUT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            x_q        <= 10'd0;
            y_q        <= 9'd0;
            word_q     <= 32'h0000_0000;
            mem_req_q  <= 1'b0;
            bg_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            word_q     <= word_d;
            mem_req_q  <= mem_req_d;
            bg_valid_q <= bg_valid_d;
        end
    end

    assign o_reqReady  = req_ready_s;
    assign o_memReq    = mem_req_q;
    assign o_memAddr   = vram_word_addr(x_q, y_q);
    assign o_bgValid   = bg_valid_q;
    assign o_scrX_Mul2 = x_q;
    assign o_scrY      = y_q;

    bg_pixel_unpack u_unpack (
        .i_word  (word_q),
        .o_r_l   (o_rBG_L),
        .o_g_l   (o_gBG_L),
        .o_b_l   (o_bgBG_L),
        .o_msk_l (o_bgMskL),
        .o_r_r   (o_rBG_R),
        .o_g_r   (o_gBG_R),
        .o_b_r   (o_bBG_R),
        .o_msk_r (o_bgMskR)
    );

endmodule

// File: tb/tb_bg_pair_reader.sv
module tb_bg_pair_reader;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_reqValid;
    logic        o_reqReady;
    logic [9:0]  i_scrX_Mul2;
    logic [8:0]  i_scrY;
    logic        i_needBG;
    logic        o_memReq;
    logic [17:0] o_memAddr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic        o_bgValid;
    logic        i_bgReady;
    logic [4:0]  o_rBG_L, o_gBG_L, o_bgBG_L, o_rBG_R, o_gBG_R, o_bBG_R;
    logic        o_bgMskL, o_bgMskR;
    logic [9:0]  o_scrX_Mul2;
    logic [8:0]  o_scrY;
    logic        i_invalidate;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bg_pair_reader dut (
        .clk            (clk),
        .i_nrst         (i_nrst),
        .i_reqValid     (i_reqValid),
        .o_reqReady     (o_reqReady),
        .i_scrX_Mul2    (i_scrX_Mul2),
        .i_scrY         (i_scrY),
        .i_needBG       (i_needBG),
        .o_memReq       (o_memReq),
        .o_memAddr      (o_memAddr),
        .i_memAck       (i_memAck),
        .i_memDataValid (i_memDataValid),
        .i_memData      (i_memData),
        .o_bgValid      (o_bgValid),
        .i_bgReady      (i_bgReady),
        .o_rBG_L        (o_rBG_L),
        .o_gBG_L        (o_gBG_L),
        .o_bgBG_L       (o_bgBG_L),
        .o_rBG_R        (o_rBG_R),
        .o_gBG_R        (o_gBG_R),
        .o_bBG_R        (o_bBG_R),
        .o_bgMskL       (o_bgMskL),
        .o_bgMskR       (o_bgMskR),
        .o_scrX_Mul2    (o_scrX_Mul2),
        .o_scrY         (o_scrY),
        .i_invalidate   (i_invalidate)
    );

    // {R_L,G_L,B_L,MskL,R_R,G_R,B_R,MskR}: 32 bits
    function automatic logic [31:0] pix_vec();
        return {o_rBG_L, o_gBG_L, o_bgBG_L, o_bgMskL, o_rBG_R, o_gBG_R, o_bBG_R, o_bgMskR};
    endfunction

    function automatic logic [31:0] mk_pix(input int rl, input int gl, input int bl, input int ml,
                                           input int rr, input int gr, input int br, input int mr);
        logic [4:0] a, b, c, d, e, f;
        a = rl[4:0]; b = gl[4:0]; c = bl[4:0]; d = rr[4:0]; e = gr[4:0]; f = br[4:0];
        return {a, b, c, ml[0], d, e, f, mr[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},   64'(o_reqReady), 64'd1);
        chk({tag, "_valid"}, 64'(o_bgValid),  64'd0);
        chk({tag, "_memreq"}, 64'(o_memReq),  64'd0);
    endtask

    logic [31:0] held_pix;

    initial begin
        i_nrst = 1'b0; i_reqValid = 1'b0; i_scrX_Mul2 = 10'd0; i_scrY = 9'd0;
        i_needBG = 1'b0; i_memAck = 1'b0; i_memDataValid = 1'b0; i_memData = 32'h0;
        i_bgReady = 1'b0; i_invalidate = 1'b0;

        // ---- reset ----
        tick(); tick();
        chk_idle("rst");
        chk("rst_addr", 64'(o_memAddr), 64'h0);
        chk("rst_pix",  64'(pix_vec()), 64'h0);
        chk("rst_echo", 64'({o_scrX_Mul2, o_scrY}), 64'h0);
        i_nrst = 1'b1;

        // ---- fetch with ack and data in the same cycle ----
        i_reqValid = 1'b1; i_scrX_Mul2 = 10'h004; i_scrY = 9'd3; i_needBG = 1'b1;
        tick();
        i_reqValid = 1'b0;
        chk("t1_memreq", 64'(o_memReq), 64'd1);
        chk("t1_addr",   64'(o_memAddr), 64'h00602);
        chk("t1_rdy",    64'(o_reqReady), 64'd0);
        i_memAck = 1'b1; i_memDataValid = 1'b1; i_memData = 32'h8421_7FFF;
        tick();
        i_memAck = 1'b0; i_memDataValid = 1'b0;
        chk("t1_valid",  64'(o_bgValid), 64'd1);
        chk("t1_memreq_off", 64'(o_memReq), 64'd0);
        chk("t1_pix",    64'(pix_vec()), 64'(mk_pix(31, 31, 31, 0, 1, 1, 1, 1)));
        chk("t1_echo",   64'({o_scrX_Mul2, o_scrY}), 64'({10'h004, 9'd3}));
        i_bgReady = 1'b1;
        tick();
        i_bgReady = 1'b0;
        chk_idle("t1_done");

        // ---- no-background request ----
        i_reqValid = 1'b1; i_scrX_Mul2 = 10'h10A; i_scrY = 9'h1F5; i_needBG = 1'b0;
        tick();
        i_reqValid = 1'b0;
        chk("t2_memreq", 64'(o_memReq), 64'd0);
        chk("t2_valid",  64'(o_bgValid), 64'd1);
        chk("t2_pix",    64'(pix_vec()), 64'h0);
        chk("t2_echo",   64'({o_scrX_Mul2, o_scrY}), 64'({10'h10A, 9'h1F5}));
        chk("t2_addr",   64'(o_memAddr), 64'h3EA85);

        // ---- consumer stalls for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_valid", 64'(o_bgValid), 64'd1);
            chk("t3_rdy",   64'(o_reqReady), 64'd0);
            chk("t3_hold",  64'({o_scrX_Mul2, o_scrY, pix_vec()}), 64'({10'h10A, 9'h1F5, 32'h0}));
        end
        i_bgReady = 1'b1; i_reqValid = 1'b1; i_scrX_Mul2 = 10'h3FE; i_scrY = 9'h1FF; i_needBG = 1'b1;
        #1;
        chk("t3_rdy_same", 64'(o_reqReady), 64'd1);
        tick();
        i_bgReady = 1'b0; i_reqValid = 1'b0;
        chk("t3_memreq", 64'(o_memReq), 64'd1);
        chk("t3_addr",   64'(o_memAddr), 64'h3FFFF);
        chk("t3_valid_off", 64'(o_bgValid), 64'd0);

        // ---- ack at cycle 2, data at cycle 6, then a stray data pulse ----
        tick();
        chk("t4_memreq_hold", 64'(o_memReq), 64'd1);
        chk("t4_addr_hold",   64'(o_memAddr), 64'h3FFFF);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_wait_valid",  64'(o_bgValid), 64'd0);
            chk("t4_wait_memreq", 64'(o_memReq), 64'd0);
            chk("t4_wait_rdy",    64'(o_reqReady), 64'd0);
            tick();
        end
        chk("t4_wait_last", 64'(o_bgValid), 64'd0);
        i_memDataValid = 1'b1; i_memData = 32'h1234_5678;
        tick();
        i_memDataValid = 1'b0;
        chk("t4_valid", 64'(o_bgValid), 64'd1);
        chk("t4_pix",   64'(pix_vec()), 64'(mk_pix(24, 19, 21, 0, 20, 17, 4, 0)));
        chk("t4_addr",  64'(o_memAddr), 64'h3FFFF);
        i_bgReady = 1'b1;
        tick();
        i_bgReady = 1'b0;
        chk_idle("t4_done");
        i_memDataValid = 1'b1; i_memData = 32'hFFFF_FFFF;
        tick();
        i_memDataValid = 1'b0;
        chk_idle("t4_stray");
        chk("t4_stray_pix", 64'(pix_vec()), 64'(mk_pix(24, 19, 21, 0, 20, 17, 4, 0)));

        // ---- repeat the same address, invalidate, then repeat again ----
        i_reqValid = 1'b1; i_scrX_Mul2 = 10'h3FE; i_scrY = 9'h1FF; i_needBG = 1'b1;
        tick();
        i_reqValid = 1'b0;
`ifdef BG_PAIR_CACHE_EN
        chk("t5_hit_memreq", 64'(o_memReq), 64'd0);
        chk("t5_hit_valid",  64'(o_bgValid), 64'd1);
        chk("t5_hit_pix",    64'(pix_vec()), 64'(mk_pix(24, 19, 21, 0, 20, 17, 4, 0)));
`else
        chk("t5_miss_memreq", 64'(o_memReq), 64'd1);
        i_memAck = 1'b1; i_memDataValid = 1'b1; i_memData = 32'h1234_5678;
        tick();
        i_memAck = 1'b0; i_memDataValid = 1'b0;
        chk("t5_miss_valid", 64'(o_bgValid), 64'd1);
`endif
        i_bgReady = 1'b1;
        tick();
        i_bgReady = 1'b0;
        i_invalidate = 1'b1;
        tick();
        i_invalidate = 1'b0;
        i_reqValid = 1'b1;
        tick();
        i_reqValid = 1'b0;
        chk("t5_inv_memreq", 64'(o_memReq), 64'd1);
        // A load and an invalidate in the same cycle must leave the cache empty.
        i_memAck = 1'b1; i_memDataValid = 1'b1; i_memData = 32'h0421_8000; i_invalidate = 1'b1;
        tick();
        i_memAck = 1'b0; i_memDataValid = 1'b0; i_invalidate = 1'b0;
        chk("t5_inv_pix", 64'(pix_vec()), 64'(mk_pix(0, 0, 0, 1, 1, 1, 1, 0)));
        i_bgReady = 1'b1;
        tick();
        i_bgReady = 1'b0;
        i_reqValid = 1'b1;
        tick();
        i_reqValid = 1'b0;
        chk("t5_inv_win_memreq", 64'(o_memReq), 64'd1);
        i_memAck = 1'b1; i_memDataValid = 1'b1;
        tick();
        i_memAck = 1'b0; i_memDataValid = 1'b0;
        i_bgReady = 1'b1;
        tick();
        i_bgReady = 1'b0;
        chk_idle("t5_done");

        // ---- reset during WAIT, then late data ----
        i_reqValid = 1'b1; i_scrX_Mul2 = 10'h020; i_scrY = 9'd1; i_needBG = 1'b1;
        tick();
        i_reqValid = 1'b0;
        chk("t6_memreq", 64'(o_memReq), 64'd1);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        chk("t6_wait", 64'(o_bgValid), 64'd0);
        i_nrst = 1'b0;
        tick();
        i_nrst = 1'b1;
        i_memDataValid = 1'b1; i_memData = 32'hAAAA_AAAA;
        tick();
        i_memDataValid = 1'b0;
        tick();
        chk_idle("t6_after");
        chk("t6_addr", 64'(o_memAddr), 64'h0);
        chk("t6_pix",  64'(pix_vec()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
